// File: rtl/sequenciador_io_if.sv
// Datapath <-> I/O sequencer signal bundle: switch-input / display-output requests,
// raw push-button and switch levels, stall and register-write results.
interface sequenciador_io_if;
  logic        in_req;
  logic        out_req;
  logic        enter;
  logic [8:0]  entradaSwitch;
  logic [31:0] out_data;
  logic        pc_stall;
  logic        reg_write_en;
  logic [31:0] write_data;
  logic [31:0] display_value;
  logic        display_valid;
  logic        busy;
  logic        timeout;

  modport master (
    output in_req, out_req, enter, entradaSwitch, out_data,
    input  pc_stall, reg_write_en, write_data, display_value, display_valid, busy, timeout
  );

  modport slave (
    input  in_req, out_req, enter, entradaSwitch, out_data,
    output pc_stall, reg_write_en, write_data, display_value, display_valid, busy, timeout
  );
endinterface

// File: rtl/sequenciador_io.sv
// I/O sequencer: stalls the PC for a debounced press/release on enter, then writes the switch value.
// Optional WAIT_PRESS timeout is enabled by defining SEQ_IO_TIMEOUT_EN.
module sequenciador_io #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input logic               clock,
  input logic               reset,
  sequenciador_io_if.slave  bus
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("sequenciador_io: parameter out of range");
  end

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, COMMIT} state_t;

  state_t      state, state_next;
  logic        sync_a, sync_b;
  logic        enter_level;
  logic [7:0]  db_count;
  logic        press_accept, release_accept;
  logic        capture_en, timeout_hit;
  logic [8:0]  captured;
  logic [31:0] write_data_reg;
  logic [31:0] display_value_reg;
  logic        display_valid_reg;

  // enter is active-low, so the idle (released) level is 1 everywhere
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_a      <= 1'b1;
      sync_b      <= 1'b1;
      enter_level <= 1'b1;
      db_count    <= '0;
    end else begin
      sync_a <= bus.enter;
      sync_b <= sync_a;
      if (sync_b != enter_level) begin
        if (db_count >= DB_LAST) begin
          enter_level <= sync_b;
          db_count    <= '0;
        end else begin
          db_count <= db_count + 8'd1;
        end
      end else begin
        db_count <= '0;
      end
    end
  end

  // Edge-like events: only a fresh acceptance counts, so a press held at entry is ignored
  assign press_accept   = (sync_b == 1'b0) && enter_level  && (db_count >= DB_LAST);
  assign release_accept = (sync_b == 1'b1) && !enter_level && (db_count >= DB_LAST);

`ifdef SEQ_IO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wait_count;
  logic          timeout_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_count  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= timeout_hit;
      if (state == WAIT_PRESS) begin
        wait_count <= wait_count + 1'b1;
      end else begin
        wait_count <= '0;
      end
    end
  end

  assign bus.timeout = timeout_reg;
`else
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    state_next  = state;
    capture_en  = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_req) begin
          state_next = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        if (press_accept) begin
          capture_en = 1'b1;
          state_next = WAIT_RELEASE;
        end
`ifdef SEQ_IO_TIMEOUT_EN
        else if (wait_count == TO_LAST) begin
          timeout_hit = 1'b1;
          state_next  = COMMIT;
        end
`endif
      end
      WAIT_RELEASE: begin
        if (release_accept) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      captured          <= '0;
      write_data_reg    <= '0;
      display_value_reg <= '0;
      display_valid_reg <= 1'b0;
    end else begin
      state <= state_next;
      if (capture_en) begin
        captured <= bus.entradaSwitch;
      end
      // write_data only changes on entry to COMMIT and holds afterwards
      if (timeout_hit) begin
        captured       <= '0;
        write_data_reg <= '0;
      end else if (state == WAIT_RELEASE && state_next == COMMIT) begin
        write_data_reg <= {{23{captured[8]}}, captured};
      end
      if (state == IDLE && bus.out_req && !bus.in_req) begin
        display_value_reg <= bus.out_data;
        display_valid_reg <= 1'b1;
      end
    end
  end

  assign bus.pc_stall      = (state == WAIT_PRESS) || (state == WAIT_RELEASE) ||
                             (state == IDLE && bus.in_req);
  assign bus.reg_write_en  = (state == COMMIT);
  assign bus.busy          = (state != IDLE);
  assign bus.write_data    = write_data_reg;
  assign bus.display_value = display_value_reg;
  assign bus.display_valid = display_valid_reg;

endmodule

// File: tb/tb_sequenciador_io.sv
// Directed bench for sequenciador_io: display vectors from a table, plus hand-written
// press/release, glitch, held-press, reset-abort and timeout sequences.
module tb_sequenciador_io;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  sequenciador_io_if bus ();

  sequenciador_io #(
    .DEBOUNCE_CYCLES (4),
    .TIMEOUT_CYCLES  (20)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        out_req;
    logic [31:0] out_data;
    logic [31:0] exp_value;
    logic        exp_valid;
  } disp_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // enter pattern: 1 (released) except for up to two low windows, indexed by cycle
  function automatic logic [63:0] make_pat(input int a0, input int alen, input int b0, input int blen);
    logic [63:0] p;
    p = '1;
    for (int i = 0; i < 64; i++) begin
      if ((i >= a0 && i < a0 + alen) || (i >= b0 && i < b0 + blen)) p[i] = 1'b0;
    end
    return p;
  endfunction

  // Applies pat[i] before edge i; on the commit cycle the datapath drops its requests
  task automatic run_seq(input string tag, input logic [63:0] pat, input int ncyc,
                         output int pulses, output logic [31:0] wd);
    logic exp_stall;
    pulses = 0;
    wd     = '0;
    for (int i = 0; i < ncyc; i++) begin
      bus.enter = pat[i];
      step();
      if (bus.reg_write_en) exp_stall = 1'b0;
      else if (bus.busy)    exp_stall = 1'b1;
      else                  exp_stall = bus.in_req;
      check({tag, " pc_stall"}, 32'(bus.pc_stall), 32'(exp_stall));
      if (bus.reg_write_en) begin
        pulses++;
        wd          = bus.write_data;
        bus.in_req  = 1'b0;
        bus.out_req = 1'b0;
      end
    end
    $display("seq %s: %0d write pulse(s), write_data=%h", tag, pulses, wd);
  endtask

  disp_vec_t   vecs[6];
  int          pulses;
  logic [31:0] wd;
  logic [31:0] held_disp;

  initial begin
    vecs[0] = '{1'b1, 32'd123,        32'd123,        1'b1};
    vecs[1] = '{1'b0, 32'd55,         32'd123,        1'b1};
    vecs[2] = '{1'b1, 32'hDEADBEEF,   32'hDEADBEEF,   1'b1};
    vecs[3] = '{1'b1, 32'h0,          32'h0,          1'b1};
    vecs[4] = '{1'b0, 32'd9,          32'h0,          1'b1};
    vecs[5] = '{1'b1, 32'h80000001,   32'h80000001,   1'b1};

    bus.in_req        = 1'b0;
    bus.out_req       = 1'b0;
    bus.enter         = 1'b1;
    bus.entradaSwitch = '0;
    bus.out_data      = '0;

    // Reset state
    #1;
    check("rst busy",          32'(bus.busy),          32'd0);
    check("rst pc_stall",      32'(bus.pc_stall),      32'd0);
    check("rst reg_write_en",  32'(bus.reg_write_en),  32'd0);
    check("rst write_data",    bus.write_data,         32'd0);
    check("rst display_value", bus.display_value,      32'd0);
    check("rst display_valid", 32'(bus.display_valid), 32'd0);
    check("rst timeout",       32'(bus.timeout),       32'd0);
    step(); step();
    reset = 1'b1;
    step();
    $display("reset released");

    // Display vectors in IDLE
    for (int v = 0; v < 6; v++) begin
      bus.out_req  = vecs[v].out_req;
      bus.out_data = vecs[v].out_data;
      #1;
      check($sformatf("disp%0d pc_stall", v), 32'(bus.pc_stall), 32'd0);
      step();
      check($sformatf("disp%0d value", v), bus.display_value, vecs[v].exp_value);
      check($sformatf("disp%0d valid", v), 32'(bus.display_valid), 32'(vecs[v].exp_valid));
      check($sformatf("disp%0d busy", v), 32'(bus.busy), 32'd0);
      $display("disp vec %0d: out_req=%0b out_data=%h -> display_value=%h",
               v, vecs[v].out_req, vecs[v].out_data, bus.display_value);
    end
    bus.out_req = 1'b0;
    step();

    // Basic input instruction: negative switch value
    bus.entradaSwitch = 9'h1F6;
    bus.in_req        = 1'b1;
    #1;
    check("in comb pc_stall", 32'(bus.pc_stall), 32'd1);
    check("in comb busy",     32'(bus.busy),     32'd0);
    run_seq("basic", make_pat(1, 4, 64, 0), 20, pulses, wd);
    check("basic pulses",     32'(pulses), 32'd1);
    check("basic write_data", wd,          32'hFFFFFFF6);
    check("basic hold",       bus.write_data, 32'hFFFFFFF6);

    // 3-cycle glitch must not be accepted; a later real press captures the new value
    bus.entradaSwitch = 9'h055;
    bus.in_req        = 1'b1;
    run_seq("glitch", make_pat(1, 3, 64, 0), 10, pulses, wd);
    check("glitch pulses",   32'(pulses),       32'd0);
    check("glitch busy",     32'(bus.busy),     32'd1);
    check("glitch pc_stall", 32'(bus.pc_stall), 32'd1);
    bus.entradaSwitch = 9'h003;
    run_seq("after_glitch", make_pat(0, 4, 64, 0), 16, pulses, wd);
    check("after_glitch pulses", 32'(pulses), 32'd1);
    check("after_glitch data",   wd,          32'h00000003);

    // in_req and out_req together: in_req wins, out_req ignored until back in IDLE
    held_disp         = bus.display_value;
    bus.entradaSwitch = 9'h0FF;
    bus.in_req        = 1'b1;
    bus.out_req       = 1'b1;
    bus.out_data      = 32'd7;
    #1;
    check("both comb pc_stall", 32'(bus.pc_stall), 32'd1);
    step();
    check("both busy",     32'(bus.busy),      32'd1);
    check("both display",  bus.display_value,  held_disp);
    run_seq("both", make_pat(0, 4, 64, 0), 16, pulses, wd);
    check("both pulses",       32'(pulses),       32'd1);
    check("both write_data",   wd,                32'h000000FF);
    check("both display kept", bus.display_value, held_disp);

    // Press already held at in_req entry: needs full release and a fresh press
    bus.enter = 1'b0;
    for (int i = 0; i < 8; i++) step();
    bus.entradaSwitch = 9'h100;
    bus.in_req        = 1'b1;
    run_seq("held", make_pat(0, 4, 10, 4), 30, pulses, wd);
    check("held pulses",     32'(pulses), 32'd1);
    check("held write_data", wd,          32'hFFFFFF00);

    // Reset during WAIT_RELEASE abandons the sequence
    bus.entradaSwitch = 9'h0AA;
    bus.in_req        = 1'b1;
    run_seq("pre_abort", make_pat(1, 4, 64, 0), 8, pulses, wd);
    check("pre_abort pulses", 32'(pulses),   32'd0);
    check("pre_abort busy",   32'(bus.busy), 32'd1);
    bus.in_req = 1'b0;
    reset      = 1'b0;
    #1;
    check("abort busy",          32'(bus.busy),          32'd0);
    check("abort reg_write_en",  32'(bus.reg_write_en),  32'd0);
    check("abort pc_stall",      32'(bus.pc_stall),      32'd0);
    check("abort display_valid", 32'(bus.display_valid), 32'd0);
    check("abort display_value", bus.display_value,      32'd0);
    check("abort write_data",    bus.write_data,         32'd0);
    step(); step();
    reset = 1'b1;
    run_seq("post_abort", make_pat(64, 0, 64, 0), 15, pulses, wd);
    check("post_abort pulses", 32'(pulses),   32'd0);
    check("post_abort busy",   32'(bus.busy), 32'd0);

`ifdef SEQ_IO_TIMEOUT_EN
    begin
      int to_pulses;
      int to_cycle;
      to_pulses         = 0;
      to_cycle          = -1;
      bus.entradaSwitch = 9'h1AB;
      bus.in_req        = 1'b1;
      bus.enter         = 1'b1;
      for (int i = 0; i < 40; i++) begin
        step();
        if (bus.timeout) begin
          to_pulses++;
          to_cycle = i;
          check("timeout reg_write_en", 32'(bus.reg_write_en), 32'd1);
          check("timeout write_data",   bus.write_data,        32'd0);
          bus.in_req = 1'b0;
        end
      end
      $display("timeout: %0d pulse(s) at cycle %0d", to_pulses, to_cycle);
      check("timeout pulses", 32'(to_pulses), 32'd1);
      check("timeout cycle",  32'(to_cycle),  32'd20);
      check("timeout idle",   32'(bus.busy),  32'd0);
    end
`else
    bus.entradaSwitch = 9'h1AB;
    bus.in_req        = 1'b1;
    bus.enter         = 1'b1;
    for (int i = 0; i < 100; i++) step();
    $display("no-timeout build: busy=%0b after 100 cycles", bus.busy);
    check("notimeout busy",     32'(bus.busy),     32'd1);
    check("notimeout pc_stall", 32'(bus.pc_stall), 32'd1);
    check("notimeout timeout",  32'(bus.timeout),  32'd0);
    run_seq("escape", make_pat(0, 4, 64, 0), 16, pulses, wd);
    check("escape pulses", 32'(pulses), 32'd1);
    check("escape data",   wd,          32'hFFFFFFAB);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sequenciador_io.md
SEQUENCIADOR_IO -- requirements
Module: sequenciador_io

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized cycles required to accept a level change on enter (range 1..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000: WAIT_PRESS timeout length; used only when SEQ_IO_TIMEOUT_EN is defined.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; ports are named as below.
REQ-004 clock  input  1  system clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_req  input  1  current instruction is a switch-input instruction; held by the datapath while stalled.
REQ-007 out_req  input  1  current instruction is a display-output instruction.
REQ-008 enter  input  1  raw push-button, active-low (0 = pressed), asynchronous.
REQ-009 entradaSwitch  input  9  raw switch value, two's complement.
REQ-010 out_data  input  32  value to display (register Rd contents).
REQ-011 pc_stall  output  1  holds PC and instruction while high.
REQ-012 reg_write_en  output  1  one-cycle register-file write strobe for the input instruction.
REQ-013 write_data  output  32  captured switch value, sign-extended to 32 bits.
REQ-014 display_value  output  32  latched display value.
REQ-015 display_valid  output  1  high once any out_req has been serviced since reset.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 timeout  output  1  one-cycle pulse when a WAIT_PRESS timeout commits.

Function
REQ-018 enter SHALL pass through a 2-flop synchronizer; the debouncer uses only the synchronized level.
REQ-019 The debouncer SHALL accept a new level after DEBOUNCE_CYCLES consecutive equal samples that differ from the accepted level; any mismatching sample clears the count; the count saturates.
REQ-020 States: IDLE, WAIT_PRESS, WAIT_RELEASE, COMMIT; encoding is implementation-defined.
REQ-021 IDLE with in_req=1 -> WAIT_PRESS next cycle; pc_stall SHALL be asserted combinationally in that same IDLE cycle.
REQ-022 IDLE with out_req=1 and in_req=0 -> display_value <= out_data and display_valid <= 1 on that edge; no stall; state stays IDLE.
REQ-023 in_req and out_req both high in IDLE: in_req wins; out_req is ignored and display_value is unchanged.
REQ-024 WAIT_PRESS: on debounced press acceptance, capture entradaSwitch into the data register and go to WAIT_RELEASE.
REQ-025 WAIT_RELEASE: on debounced release acceptance -> COMMIT; a press already held at in_req entry SHALL still require a full release and a fresh press.
REQ-026 COMMIT: reg_write_en=1 and pc_stall=0 for exactly one cycle; write_data = {23 copies of bit 8, captured[8:0]}; then -> IDLE.
REQ-027 pc_stall = 1 in WAIT_PRESS and WAIT_RELEASE, and in IDLE when in_req=1; otherwise 0.
REQ-028 write_data SHALL hold its last captured value outside COMMIT.
REQ-029 in_req or out_req SHALL be ignored outside IDLE.

Reset
REQ-030 reset low SHALL immediately force state IDLE, debounce count 0, accepted enter level and synchronizer flops to 1, and all outputs to 0, including display_value, display_valid and write_data.
REQ-031 reset asserted mid-sequence SHALL abandon the sequence with no reg_write_en pulse; operation resumes on the first edge after release.

Configuration
REQ-032 With SEQ_IO_TIMEOUT_EN defined, a cycle counter runs in WAIT_PRESS.
REQ-033 After TIMEOUT_CYCLES cycles with no accepted press, captured value = 0, timeout pulses 1 cycle, and the state goes directly to COMMIT.
REQ-034 Without SEQ_IO_TIMEOUT_EN, no counter exists, WAIT_PRESS waits indefinitely, and timeout is tied to 0.

Verification
REQ-035 Reset with enter=1 -> all outputs 0 and busy=0; assert reset mid-WAIT_RELEASE -> state IDLE, no reg_write_en.
REQ-036 in_req=1, entradaSwitch=9'h1F6, enter low 4 cycles then high 4 cycles -> single reg_write_en pulse, write_data=32'hFFFFFFF6, pc_stall high from the in_req cycle until COMMIT.
REQ-037 Enter glitches low for 3 cycles (DEBOUNCE_CYCLES=4) -> no capture, state stays WAIT_PRESS.
REQ-038 out_req=1, out_data=32'd123 in IDLE -> display_value=123 and display_valid=1 next cycle; pc_stall stays 0.
REQ-039 in_req and out_req high together, out_data=7 -> WAIT_PRESS entered, display_value unchanged.
REQ-040 SEQ_IO_TIMEOUT_EN defined, TIMEOUT_CYCLES=20, no press -> timeout pulse, write_data=0, reg_write_en pulse; without the macro -> busy stays high after 100 cycles.
